// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: drives a single-port memory bus through one write burst followed by a
// read-back burst. Both bursts start at the same base address.
//
// Each run writes seed+k to base+k for wr_len beats. It then reads base+k for rd_len beats
// and counts every read value that differs from seed+k.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_start              run request, honoured only when idle
//   i_base_addr          first address of both bursts (latched on start)
//   i_wr_len, i_rd_len   beat counts, 0 skips that phase (latched on start)
//   i_seed               data seed (latched on start)
//   i_mem_ready          memory accepts the beat currently on the bus
//   i_rdata              read data, valid one cycle after an accepted read beat
//   o_en, o_wr           registered bus enable / write strobe
//   o_addr, o_wdata      registered beat address / write data (wdata 0 on reads)
//   o_busy, o_done       not idle / one-cycle end-of-run pulse
//   o_err_cnt            saturating read-mismatch count for the current or last run
module mem_seq_ctrl #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 8,
  parameter int unsigned LW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_base_addr,
  input  logic [LW-1:0] i_wr_len,
  input  logic [LW-1:0] i_rd_len,
  input  logic [DW-1:0] i_seed,
  input  logic          i_mem_ready,
  input  logic [DW-1:0] i_rdata,
  output logic          o_en,
  output logic          o_wr,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wdata,
  output logic          o_busy,
  output logic          o_done,
  output logic [LW-1:0] o_err_cnt
);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StFlush, StDone} state_e;

  localparam logic [LW-1:0] ErrMax = '1;

  state_e        r_state, w_state_d;
  logic [AW-1:0] r_base;
  logic [LW-1:0] r_wr_len, r_rd_len;
  logic [DW-1:0] r_seed;
  logic [LW-1:0] r_beat, w_beat_d;
  logic [DW-1:0] r_exp;
  logic          r_cmp_pend;
  logic [LW-1:0] r_err_cnt;
  logic          r_en, r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic          w_start_acc, w_beat_acc, w_rd_acc, w_wr_last, w_rd_last;
  logic [AW-1:0] w_base_d;
  logic [DW-1:0] w_seed_d;
  logic          w_en_d, w_wr_d;
  logic [AW-1:0] w_addr_d;
  logic [DW-1:0] w_wdata_d;

  assign w_start_acc = (r_state == StIdle) && i_start;
  assign w_beat_acc  = r_en && i_mem_ready;
  assign w_rd_acc    = (r_state == StRead) && w_beat_acc;
  assign w_wr_last   = (r_beat == r_wr_len - LW'(1));
  assign w_rd_last   = (r_beat == r_rd_len - LW'(1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Next-state and beat counter
  always_comb begin
    w_state_d = r_state;
    w_beat_d  = r_beat;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_beat_d = '0;
          if (i_wr_len != '0)      w_state_d = StWrite;
          else if (i_rd_len != '0) w_state_d = StRead;
          else                     w_state_d = StDone;
        end
      end
      StWrite: begin
        if (w_beat_acc) begin
          if (w_wr_last) begin
            w_beat_d  = '0;
            w_state_d = (r_rd_len != '0) ? StRead : StDone;
          end else begin
            w_beat_d = r_beat + LW'(1);
          end
        end
      end
      StRead: begin
        if (w_beat_acc) begin
          w_beat_d = r_beat + LW'(1);
          if (w_rd_last) w_state_d = StFlush;
        end
      end
      StFlush: w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Bus outputs are registered. Their next value follows the next state and beat, so the
  // first beat appears the cycle after start, and a stalled beat holds because neither
  // the state nor the beat count moves.
  always_comb begin
    w_base_d  = w_start_acc ? i_base_addr : r_base;
    w_seed_d  = w_start_acc ? i_seed : r_seed;
    w_en_d    = 1'b0;
    w_wr_d    = 1'b0;
    w_addr_d  = '0;
    w_wdata_d = '0;
    if (w_state_d == StWrite) begin
      w_en_d    = 1'b1;
      w_wr_d    = 1'b1;
      w_addr_d  = w_base_d + AW'(w_beat_d);
      w_wdata_d = w_seed_d + DW'(w_beat_d);
    end else if (w_state_d == StRead) begin
      w_en_d   = 1'b1;
      w_addr_d = w_base_d + AW'(w_beat_d);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_base     <= '0;
      r_wr_len   <= '0;
      r_rd_len   <= '0;
      r_seed     <= '0;
      r_beat     <= '0;
      r_exp      <= '0;
      r_cmp_pend <= 1'b0;
      r_err_cnt  <= '0;
      r_en       <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_beat  <= w_beat_d;
      r_en    <= w_en_d;
      r_wr    <= w_wr_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
      if (w_start_acc) begin
        r_base   <= i_base_addr;
        r_wr_len <= i_wr_len;
        r_rd_len <= i_rd_len;
        r_seed   <= i_seed;
      end
      // rdata for an accepted read is checked on the following edge, which for the last
      // read falls in FLUSH.
      r_cmp_pend <= w_rd_acc;
      if (w_rd_acc) r_exp <= r_seed + DW'(r_beat);
      if (w_start_acc) begin
        r_err_cnt <= '0;
      end else if (r_cmp_pend && (i_rdata != r_exp) && (r_err_cnt != ErrMax)) begin
        r_err_cnt <= r_err_cnt + LW'(1);
      end
    end
  end

  assign o_en      = r_en;
  assign o_wr      = r_wr;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;
  assign o_busy    = (r_state != StIdle);
  assign o_done    = (r_state == StDone);
  assign o_err_cnt = r_err_cnt;

endmodule
